cdb_scheduler: RTL and testbench
================================

CDB_SCHEDULER -- requirements
Module: cdb_scheduler

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 4, meaning the number of execution units sharing the CDB (legal range 2..8).
REQ-002 SHALL have parameter DATA_W, default 32, meaning the CDB data width.
REQ-003 SHALL have parameter TAG_W, default 6, meaning the rename tag width.
REQ-004 SHALL have parameter SLOT_DEPTH, default 8, meaning the number of CDB reservation slots.
REQ-005 SHALL have parameter UNIT_LAT, default {4'd1,4'd6,4'd3,4'd1}, meaning packed 4-bit latency per unit, unit0 in the LSBs (LS=1, MULT=3, DIV=6, INT=1).
REQ-006 SHALL have parameter UNIT_PIPE, default 4'b1011, meaning that bit u=1 makes unit u pipelined (DIV is not pipelined).
REQ-007 SHALL have port clk, input, 1 bit: the single clock.
REQ-008 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port req, input, NUM_UNITS bits: unit u has an issue-ready instruction.
REQ-010 SHALL have port grant, output, NUM_UNITS bits: combinational same-cycle issue acknowledge (the queue "done").
REQ-011 SHALL have ports res_data, input, NUM_UNITS*DATA_W bits, and res_tag, input, NUM_UNITS*TAG_W bits: per-unit result buses.
REQ-012 SHALL have ports res_branch and res_branch_taken, input, NUM_UNITS bits each: per-unit branch flags.
REQ-013 SHALL have port flush, input, 1 bit: synchronous kill of all in-flight reservations.
REQ-014 SHALL have ports cdb_valid (1), cdb_data (DATA_W), cdb_tag (TAG_W), cdb_branch (1), cdb_branch_taken (1) and cdb_owner ($clog2(NUM_UNITS)), all outputs: the registered CDB.

Function
REQ-015 SHALL hold a reservation vector occ_r[SLOT_DEPTH-1:0] and an owner id per slot; every cycle the vector shifts one slot toward index 0.
REQ-016 SHALL grant unit u in cycle t only if req[u]=1, occ_r[L_u]=0, unit u is not busy, flush=0, and u wins arbitration.
REQ-017 SHALL, on a grant, set occ[L_u-1] and owner[L_u-1]=u in the next state, so the slot reaches index 0 in cycle t+L_u.
REQ-018 SHALL treat the unit's result as valid on res_*[u] in cycle t+L_u; in that cycle occ_r[0]=1 and owner_r[0]=u.
REQ-019 SHALL register the result into cdb_* in cycle t+L_u, so the result is visible on the CDB in cycle t+L_u+1 (latency L_u+1 from grant).
REQ-020 SHALL drive cdb_valid=0 and all other cdb_* fields to 0 in any cycle whose preceding cycle had occ_r[0]=0.
REQ-021 SHALL arbitrate contenders of equal latency (the only possible slot conflict) round-robin from a global pointer rr_r.
REQ-022 SHALL advance rr_r to winner+1 (mod NUM_UNITS) only when two or more units contended; an uncontended grant leaves rr_r unchanged.
REQ-023 SHALL, for a unit with UNIT_PIPE[u]=0, mark it busy for L_u cycles after its grant; it becomes grantable again in cycle t+L_u.
REQ-024 SHALL allow at most one grant per latency class per cycle; units of different latency may be granted in the same cycle.
REQ-025 SHALL, on flush=1, produce zero grants, clear occ, owners and busy counters next cycle, and deassert cdb_valid the following cycle; rr_r is preserved.
REQ-026 SHALL give flush priority when it coincides with req or with occ_r[0]: no grant is issued and no CDB write occurs.
REQ-027 SHALL reject at elaboration any UNIT_LAT entry that is 0 or >= SLOT_DEPTH, and any NUM_UNITS outside 2..8.

Reset
REQ-028 SHALL, with reset=0 (asynchronous), clear occ_r, owner_r, busy counters, rr_r=0 and all cdb_* outputs to 0.
REQ-029 SHALL keep grant=0 while reset=0; reset asserted mid-operation discards all reservations, and no late CDB write occurs after release.

Structure
REQ-030 SHALL define the default UNIT_LAT and UNIT_PIPE values, unit-index constants (LS, MULT, DIV, INT) and TAG_W in a shared package.
REQ-031 SHALL contain one sub-module, rr_arbiter (parameterised request width, pointer in, one-hot grant out), instantiated once per latency class.

Verification
REQ-032 SHALL cover: INT req in cycle 0 with res_data=32'h1234 and res_tag=5 -> grant[3]=1 in cycle 0; cdb_valid=1, cdb_data=32'h1234, cdb_tag=5, cdb_owner=3 in cycle 2.
REQ-033 SHALL cover: INT and LS requesting every cycle for 4 cycles -> grants alternate LS, INT, LS, INT from rr_r=0, with one CDB write per cycle.
REQ-034 SHALL cover: MULT granted in cycle 0 and INT requesting in cycle 2 -> INT blocked in cycle 2 (occ_r[1] set) and granted in cycle 3; CDB carries MULT in cycle 4 and INT in cycle 5.
REQ-035 SHALL cover: DIV req held high from cycle 0 -> grants only in cycles 0 and 6, with CDB writes in cycles 7 and 13.
REQ-036 SHALL cover: MULT granted in cycle 0 and flush in cycle 1 -> no CDB write in cycle 4; a new INT req in cycle 2 is granted.
REQ-037 SHALL cover: reset asserted in cycle 2 after a DIV grant in cycle 0 -> all outputs 0 immediately and no CDB write after release.

Source files
------------

// File: rtl/cdb_scheduler_pkg.sv
// Shared constants for the CDB scheduler: default unit latencies, pipelining
// mask, unit indices and helpers that decode the packed latency vector.
package cdb_scheduler_pkg;

    localparam int LS   = 0;
    localparam int MULT = 1;
    localparam int DIV  = 2;
    localparam int INT  = 3;

    localparam int TAG_W_DEF = 6;
    localparam int LAT_W     = 4;

    localparam logic [4*LAT_W-1:0] UNIT_LAT_DEF  = {4'd1, 4'd6, 4'd3, 4'd1};
    localparam logic [3:0]         UNIT_PIPE_DEF = 4'b1011;

    // Latency of unit u from a packed latency vector (unit0 in the LSBs).
    function automatic logic [LAT_W-1:0] lat_of(input logic [8*LAT_W-1:0] lats, input int u);
        return lats[u*LAT_W +: LAT_W];
    endfunction

    // Bit u set when unit u belongs to latency class c.
    function automatic logic [7:0] class_mask(input logic [8*LAT_W-1:0] lats, input int n, input int c);
        logic [7:0] m;
        m = '0;
        for (int u = 0; u < n; u++)
            if (int'(lats[u*LAT_W +: LAT_W]) == c) m[u] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/cdb_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the requester closest to ptr going upward
// (wrapping), returns a one-hot grant. Purely combinational.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);

    int best;
    int win;

    // Smallest cyclic distance from ptr among active requesters wins.
    always_comb begin
        best = N;
        win  = 0;
        for (int u = 0; u < N; u++) begin
            if (req[u] && (((u + N - int'(ptr)) % N) < best)) begin
                best = (u + N - int'(ptr)) % N;
                win  = u;
            end
        end
        gnt = '0;
        for (int u = 0; u < N; u++)
            gnt[u] = (best < N) && (win == u);
    end

endmodule

// File: rtl/cdb_scheduler.sv
// CDB scheduler: reserves a common-data-bus slot at issue time so each unit's
// result lands on the registered CDB exactly L_u+1 cycles after its grant.
module cdb_scheduler
    import cdb_scheduler_pkg::*;
#(
    parameter int                          NUM_UNITS  = 4,
    parameter int                          DATA_W     = 32,
    parameter int                          TAG_W      = TAG_W_DEF,
    parameter int                          SLOT_DEPTH = 8,
    parameter logic [NUM_UNITS*LAT_W-1:0]  UNIT_LAT   = UNIT_LAT_DEF,
    parameter logic [NUM_UNITS-1:0]        UNIT_PIPE  = UNIT_PIPE_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_UNITS-1:0]          req,
    output logic [NUM_UNITS-1:0]          grant,
    input  logic [NUM_UNITS*DATA_W-1:0]   res_data,
    input  logic [NUM_UNITS*TAG_W-1:0]    res_tag,
    input  logic [NUM_UNITS-1:0]          res_branch,
    input  logic [NUM_UNITS-1:0]          res_branch_taken,
    input  logic                          flush,
    output logic                          cdb_valid,
    output logic [DATA_W-1:0]             cdb_data,
    output logic [TAG_W-1:0]              cdb_tag,
    output logic                          cdb_branch,
    output logic                          cdb_branch_taken,
    output logic [$clog2(NUM_UNITS)-1:0]  cdb_owner
);

    localparam int                 OW   = $clog2(NUM_UNITS);
    localparam logic [8*LAT_W-1:0] LATS = (8*LAT_W)'(UNIT_LAT);

    logic [SLOT_DEPTH-1:0]                occ_r, occ_nxt;
    logic [SLOT_DEPTH-1:0][OW-1:0]        owner_r, owner_nxt;
    logic [NUM_UNITS-1:0][LAT_W-1:0]      busy_r, busy_nxt;
    logic [OW-1:0]                        rr_r, rr_nxt;
    logic [NUM_UNITS-1:0]                 elig;
    logic [SLOT_DEPTH-1:1][NUM_UNITS-1:0] cls_gnt;
    logic [SLOT_DEPTH-1:1]                cls_multi;
    logic                                 rr_hit;
    logic [DATA_W-1:0]                    sel_data;
    logic [TAG_W-1:0]                     sel_tag;
    logic                                 sel_br, sel_tk;

    if (NUM_UNITS < 2 || NUM_UNITS > 8) begin : g_bad_units
        $error("cdb_scheduler: NUM_UNITS must be in 2..8");
    end

    // A unit may issue only if its completion slot is free and it is idle.
    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
        localparam int L = int'(lat_of(LATS, u));
        if (L == 0 || L >= SLOT_DEPTH) begin : g_bad_lat
            $error("cdb_scheduler: UNIT_LAT entry must be 1..SLOT_DEPTH-1");
        end
        assign elig[u] = reset && !flush && req[u] && !occ_r[(L < SLOT_DEPTH) ? L : 0]
                         && (busy_r[u] == '0);
    end

    // Units sharing a latency share a completion slot, so each class gets an arbiter.
    for (genvar c = 1; c < SLOT_DEPTH; c++) begin : g_cls
        localparam logic [7:0] CMASK = class_mask(LATS, NUM_UNITS, c);
        if (CMASK != 8'd0) begin : g_arb
            logic [NUM_UNITS-1:0] creq;
            assign creq         = elig & CMASK[NUM_UNITS-1:0];
            assign cls_multi[c] = $countones(creq) > 1;
            rr_arbiter #(.N(NUM_UNITS)) u_arb (
                .req (creq),
                .ptr (rr_r),
                .gnt (cls_gnt[c])
            );
        end else begin : g_none
            assign cls_multi[c] = 1'b0;
            assign cls_gnt[c]   = '0;
        end
    end

    // Merge class grants; the first contended class moves the shared pointer.
    always_comb begin
        grant  = '0;
        rr_nxt = rr_r;
        rr_hit = 1'b0;
        for (int c = 1; c < SLOT_DEPTH; c++) begin
            grant |= cls_gnt[c];
            if (!rr_hit && cls_multi[c]) begin
                rr_hit = 1'b1;
                for (int u = 0; u < NUM_UNITS; u++)
                    if (cls_gnt[c][u]) rr_nxt = OW'((u + 1) % NUM_UNITS);
            end
        end
    end

    // Shift reservations toward slot 0 and book L-1 for each granted class.
    always_comb begin
        occ_nxt   = occ_r >> 1;
        owner_nxt = owner_r >> OW;
        for (int c = 1; c < SLOT_DEPTH; c++) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (cls_gnt[c][u]) begin
                    occ_nxt[c-1]   = 1'b1;
                    owner_nxt[c-1] = OW'(u);
                end
            end
        end
        for (int u = 0; u < NUM_UNITS; u++) begin
            busy_nxt[u] = (busy_r[u] != '0) ? busy_r[u] - 1'b1 : '0;
            if (grant[u] && !UNIT_PIPE[u]) busy_nxt[u] = lat_of(LATS, u) - 1'b1;
        end
    end

    // Scheduler state; flush kills reservations but keeps the fairness pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_r   <= '0;
            owner_r <= '0;
            busy_r  <= '0;
            rr_r    <= '0;
        end else if (flush) begin
            occ_r   <= '0;
            owner_r <= '0;
            busy_r  <= '0;
        end else begin
            occ_r   <= occ_nxt;
            owner_r <= owner_nxt;
            busy_r  <= busy_nxt;
            rr_r    <= rr_nxt;
        end
    end

    // Select the result bus of the unit owning slot 0.
    always_comb begin
        sel_data = '0;
        sel_tag  = '0;
        sel_br   = 1'b0;
        sel_tk   = 1'b0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (owner_r[0] == OW'(u)) begin
                sel_data = res_data[u*DATA_W +: DATA_W];
                sel_tag  = res_tag[u*TAG_W +: TAG_W];
                sel_br   = res_branch[u];
                sel_tk   = res_branch_taken[u];
            end
        end
    end

    // Registered CDB: written only when slot 0 is reserved and no flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cdb_valid        <= 1'b0;
            cdb_data         <= '0;
            cdb_tag          <= '0;
            cdb_branch       <= 1'b0;
            cdb_branch_taken <= 1'b0;
            cdb_owner        <= '0;
        end else if (occ_r[0] && !flush) begin
            cdb_valid        <= 1'b1;
            cdb_data         <= sel_data;
            cdb_tag          <= sel_tag;
            cdb_branch       <= sel_br;
            cdb_branch_taken <= sel_tk;
            cdb_owner        <= owner_r[0];
        end else begin
            cdb_valid        <= 1'b0;
            cdb_data         <= '0;
            cdb_tag          <= '0;
            cdb_branch       <= 1'b0;
            cdb_branch_taken <= 1'b0;
            cdb_owner        <= '0;
        end
    end

endmodule

// File: tb/tb_cdb_scheduler.sv
// Bench for cdb_scheduler: a completion-calendar model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_cdb_scheduler;
    import cdb_scheduler_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TW = 6;
    localparam int SD = 8;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic [N-1:0]  req   = '0;
    logic [N-1:0]  grant;
    logic [N*DW-1:0] res_data = '0;
    logic [N*TW-1:0] res_tag  = '0;
    logic [N-1:0]  res_branch       = '0;
    logic [N-1:0]  res_branch_taken = '0;
    logic          cdb_valid;
    logic [DW-1:0] cdb_data;
    logic [TW-1:0] cdb_tag;
    logic          cdb_branch;
    logic          cdb_branch_taken;
    logic [1:0]    cdb_owner;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cdb_scheduler dut (
        .clk              (clk),
        .reset            (reset),
        .req              (req),
        .grant            (grant),
        .res_data         (res_data),
        .res_tag          (res_tag),
        .res_branch       (res_branch),
        .res_branch_taken (res_branch_taken),
        .flush            (flush),
        .cdb_valid        (cdb_valid),
        .cdb_data         (cdb_data),
        .cdb_tag          (cdb_tag),
        .cdb_branch       (cdb_branch),
        .cdb_branch_taken (cdb_branch_taken),
        .cdb_owner        (cdb_owner)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: a calendar of completion cycles ----------------
    int  lat_m  [N] = '{1, 3, 6, 1};
    bit  pipe_m [N] = '{1, 1, 0, 1};
    bit  pend_v [16];
    int  pend_o [16];
    int  busy_until [N];
    int  rr_m = 0;
    int  mcyc = 0;
    logic          e_valid = 1'b0;
    logic [DW-1:0] e_data  = '0;
    logic [TW-1:0] e_tag   = '0;
    logic          e_br    = 1'b0;
    logic          e_tk    = 1'b0;
    int            e_own   = 0;

    always @(negedge clk) begin : model
        logic [N-1:0] eg;
        int cands, w, u, rr_next, slot;
        bit rr_moved;
        eg = '0;
        rr_next = rr_m;
        rr_moved = 1'b0;
        if (!reset) begin
            for (int i = 0; i < 16; i++) pend_v[i] = 1'b0;
            for (int i = 0; i < N; i++) busy_until[i] = 0;
            rr_m = 0; rr_next = 0;
            e_valid = 1'b0; e_data = '0; e_tag = '0; e_br = 1'b0; e_tk = 1'b0; e_own = 0;
        end else if (!flush) begin
            // one completion per cycle: a unit may issue only into a free future cycle
            for (int lv = 1; lv < SD; lv++) begin
                cands = 0; w = -1;
                for (int k = 0; k < N; k++) begin
                    u = (rr_m + k) % N;
                    if (lat_m[u] == lv && req[u] && mcyc >= busy_until[u] && !pend_v[(mcyc + lv) % 16]) begin
                        cands++;
                        if (w < 0) w = u;
                    end
                end
                if (w >= 0) eg[w] = 1'b1;
                if (cands >= 2 && !rr_moved) begin rr_next = (w + 1) % N; rr_moved = 1'b1; end
            end
        end
        check("model_grant", grant, eg);
        check("model_valid", cdb_valid, e_valid);
        check("model_data", cdb_data, e_data);
        check("model_tag", cdb_tag, e_tag);
        check("model_branch", cdb_branch, e_br);
        check("model_taken", cdb_branch_taken, e_tk);
        check("model_owner", cdb_owner, e_own);
        if (reset) begin
            slot = mcyc % 16;
            if (!flush && pend_v[slot]) begin
                e_valid = 1'b1;
                e_data  = res_data[pend_o[slot]*DW +: DW];
                e_tag   = res_tag[pend_o[slot]*TW +: TW];
                e_br    = res_branch[pend_o[slot]];
                e_tk    = res_branch_taken[pend_o[slot]];
                e_own   = pend_o[slot];
            end else begin
                e_valid = 1'b0; e_data = '0; e_tag = '0; e_br = 1'b0; e_tk = 1'b0; e_own = 0;
            end
            pend_v[slot] = 1'b0;
            if (flush) begin
                for (int i = 0; i < 16; i++) pend_v[i] = 1'b0;
                for (int i = 0; i < N; i++) busy_until[i] = 0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (eg[i]) begin
                        pend_v[(mcyc + lat_m[i]) % 16] = 1'b1;
                        pend_o[(mcyc + lat_m[i]) % 16] = i;
                        if (!pipe_m[i]) busy_until[i] = mcyc + lat_m[i];
                    end
                end
            end
            rr_m = rr_next;
        end
        mcyc++;
    end

    // ---------------- stimulus ----------------
    int scyc = 0;
    bit int_fix = 1'b0;

    // Drive one cycle of inputs just after the edge, return mid-cycle.
    task automatic tick(input logic [N-1:0] r, input logic fl = 1'b0, input logic rs = 1'b1);
        @(posedge clk);
        #1;
        req = r; flush = fl; reset = rs;
        scyc++;
        for (int u = 0; u < N; u++) begin
            res_data[u*DW +: DW]  = {4'hD, 4'(u), 8'h5A, 16'(scyc)};
            res_tag[u*TW +: TW]   = 6'((u * 13 + scyc) % 64);
            res_branch[u]         = ((scyc + u) % 3) == 0;
            res_branch_taken[u]   = ((scyc + u) % 2) == 1;
        end
        if (int_fix) begin
            res_data[INT*DW +: DW] = 32'h1234;
            res_tag[INT*TW +: TW]  = 6'd5;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick('0);
    endtask

    logic [3:0] mix_req [16] = '{4'b1111, 4'b1111, 4'b1111, 4'b0101, 4'b1011, 4'b1001, 4'b0010, 4'b1110,
                                 4'b1111, 4'b1111, 4'b1101, 4'b1111, 4'b0110, 4'b1001, 4'b1111, 4'b0011};
    bit         mix_fl  [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};

    initial begin
        // reset: requests held high must not be granted, CDB cleared
        tick(4'b1111, 1'b0, 1'b0);
        tick(4'b1111, 1'b0, 1'b0);
        check("rst_grant", grant, 4'b0000);
        check("rst_valid", cdb_valid, 1'b0);
        check("rst_data", cdb_data, 32'h0);
        check("rst_owner", cdb_owner, 2'd0);
        idle(2);

        // single INT issue, result on CDB two cycles later
        int_fix = 1'b1;
        tick(4'b1000);
        check("t1_grant", grant, 4'b1000);
        tick('0);
        tick('0);
        check("t1_valid", cdb_valid, 1'b1);
        check("t1_data", cdb_data, 32'h1234);
        check("t1_tag", cdb_tag, 6'd5);
        check("t1_owner", cdb_owner, 2'd3);
        int_fix = 1'b0;
        idle(4);

        // LS and INT contend: round-robin alternation, one write per cycle
        for (int c = 0; c < 6; c++) begin
            tick(c < 4 ? 4'b1001 : 4'b0000);
            if (c < 4) check("t2_grant", grant, (c % 2 == 0) ? 4'b0001 : 4'b1000);
            if (c >= 2) begin
                check("t2_valid", cdb_valid, 1'b1);
                check("t2_owner", cdb_owner, (c % 2 == 0) ? 2'd0 : 2'd3);
            end
        end
        idle(4);

        // MULT blocks a later INT that would land in the same cycle
        tick(4'b0010); check("t3_grant0", grant, 4'b0010);
        tick('0);
        tick(4'b1000); check("t3_blocked", grant, 4'b0000);
        tick(4'b1000); check("t3_grant3", grant, 4'b1000);
        tick('0);      check("t3_v4", cdb_valid, 1'b1); check("t3_own4", cdb_owner, 2'd1);
        tick('0);      check("t3_v5", cdb_valid, 1'b1); check("t3_own5", cdb_owner, 2'd3);
        tick('0);      check("t3_v6", cdb_valid, 1'b0);
        idle(4);

        // non-pipelined DIV: re-grant only after its latency elapses
        for (int c = 0; c < 15; c++) begin
            tick(c < 12 ? 4'b0100 : 4'b0000);
            check("t4_grant", grant[DIV], (c == 0 || c == 6));
            check("t4_valid", cdb_valid, (c == 7 || c == 13));
            if (c == 7 || c == 13) check("t4_owner", cdb_owner, 2'd2);
        end
        idle(4);

        // flush kills an in-flight MULT; INT issued after flush gets the bus
        tick(4'b0010);       check("t5_grant0", grant, 4'b0010);
        tick('0, 1'b1);      check("t5_flush_grant", grant, 4'b0000);
        tick(4'b1000);       check("t5_grant2", grant, 4'b1000); check("t5_v2", cdb_valid, 1'b0);
        tick('0);            check("t5_v3", cdb_valid, 1'b0);
        tick('0);            check("t5_v4", cdb_valid, 1'b1); check("t5_own4", cdb_owner, 2'd3);
        tick('0);            check("t5_v5", cdb_valid, 1'b0);
        idle(3);

        // flush coinciding with req and with a due result; pointer survives flush
        tick(4'b1001);       check("t5b_grant0", grant, 4'b0001);
        tick(4'b1001, 1'b1); check("t5b_flush_grant", grant, 4'b0000);
        tick(4'b1001);       check("t5b_grant2", grant, 4'b1000); check("t5b_v2", cdb_valid, 1'b0);
        tick('0);            check("t5b_v3", cdb_valid, 1'b0);
        tick('0);            check("t5b_v4", cdb_valid, 1'b1); check("t5b_own4", cdb_owner, 2'd3);
        idle(4);

        // reset mid-flight discards the DIV reservation and its busy time
        tick(4'b0100);             check("t6_grant0", grant, 4'b0100);
        tick('0);
        tick(4'b0100, 1'b0, 1'b0); check("t6_rst_grant", grant, 4'b0000);
        check("t6_rst_valid", cdb_valid, 1'b0);
        tick('0);
        tick(4'b0100);             check("t6_regrant", grant, 4'b0100);
        for (int c = 5; c < 11; c++) begin
            tick('0);
            check("t6_no_late", cdb_valid, 1'b0);
        end
        tick('0);                  check("t6_v11", cdb_valid, 1'b1); check("t6_own11", cdb_owner, 2'd2);
        idle(4);

        // mixed traffic across latency classes, checked by the model only
        for (int i = 0; i < 16; i++) tick(mix_req[i], mix_fl[i]);
        idle(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
